// File: rtl/prefix_subtractor_pipe_if.sv
// prefix_subtractor_pipe_if
//   Operand/result bundle for prefix_subtractor_pipe.
//   Upstream side : in_valid, in_ready, a, b
//   Downstream side: out_valid, out_ready, diff, borrow, zero, ovf
//   master - the environment that supplies operands and consumes results
//   slave  - the subtractor pipeline itself
interface prefix_subtractor_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, zero, ovf
  );
endinterface

// File: rtl/prefix_subtractor_pipe.sv
// prefix_subtractor_pipe
//   Pipelined 8-bit subtractor: diff = a - b computed as a + ~b + 1 on a
//   3-level Ladner-Fischer prefix carry network. Stages:
//     S1 : per-bit p/g/h of a and ~b, plus the operand sign bits
//     S2 : level-2 group P/G (only when PIPE_MID = 1)
//     SO : level-3 prefix, sum bits and flags (borrow, zero, ovf)
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset, clears every stage
//     bus  - prefix_subtractor_pipe_if.slave (operand and result handshakes)
//
// Handshake: a word moves across a boundary on a clock edge where valid and
// ready are both high. Each stage holds its contents until it advances; a
// stage advances when its successor is empty or is itself advancing in the
// same cycle. in_ready is therefore combinational from out_ready through the
// stage chain (no skid buffer), and a held result stays stable while
// out_ready is low.
module prefix_subtractor_pipe #(
  parameter int WIDTH    = 8,
  parameter int PIPE_MID = 1
) (
  input logic                    clk,
  input logic                    rst,
  prefix_subtractor_pipe_if.slave bus
);

  // ---------------- S1: bitwise propagate/generate/half-sum ----------------
  logic [WIDTH-1:0] bb, p_in, g_in, h_in;
  assign bb   = ~bus.b;
  assign p_in = bus.a | bb;
  assign g_in = bus.a & bb;
  assign h_in = bus.a ^ bb;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p, s1_g, s1_h;
  logic             s1_a7, s1_b7;
  logic             s1_adv;
  logic             accept;

  assign bus.in_ready = ~s1_valid | s1_adv;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_h     <= '0;
      s1_a7    <= 1'b0;
      s1_b7    <= 1'b0;
    end else begin
      s1_valid <= accept | (s1_valid & ~s1_adv);
      if (accept) begin
        s1_p  <= p_in;
        s1_g  <= g_in;
        s1_h  <= h_in;
        s1_a7 <= bus.a[7];
        s1_b7 <= bus.b[7];
      end
    end
  end

  // ---------------- prefix levels 1 and 2 ----------------
  // The forced carry-in of 1 turns bit 0 into a pure generate: G0 = g0 | p0.
  // Group P is only formed where a later level still needs it.
  logic [WIDTH-1:0] l1_g, l2_g;
  logic [WIDTH-1:2] l1_p;
  logic [WIDTH-1:4] l2_p;

  assign l1_g[0] = s1_g[0] | s1_p[0];
  assign l1_g[1] = s1_g[1] | (s1_p[1] & l1_g[0]);
  assign l1_g[2] = s1_g[2];
  assign l1_g[3] = s1_g[3] | (s1_p[3] & s1_g[2]);
  assign l1_g[4] = s1_g[4];
  assign l1_g[5] = s1_g[5] | (s1_p[5] & s1_g[4]);
  assign l1_g[6] = s1_g[6];
  assign l1_g[7] = s1_g[7] | (s1_p[7] & s1_g[6]);
  assign l1_p[2] = s1_p[2];
  assign l1_p[3] = s1_p[3] & s1_p[2];
  assign l1_p[4] = s1_p[4];
  assign l1_p[5] = s1_p[5] & s1_p[4];
  assign l1_p[6] = s1_p[6];
  assign l1_p[7] = s1_p[7] & s1_p[6];

  // Level 2: bits 2,3 reach bit 0 through group [1:0]; bits 6,7 form [7:4].
  assign l2_g[0] = l1_g[0];
  assign l2_g[1] = l1_g[1];
  assign l2_g[2] = l1_g[2] | (l1_p[2] & l1_g[1]);
  assign l2_g[3] = l1_g[3] | (l1_p[3] & l1_g[1]);
  assign l2_g[4] = l1_g[4];
  assign l2_g[5] = l1_g[5];
  assign l2_g[6] = l1_g[6] | (l1_p[6] & l1_g[5]);
  assign l2_g[7] = l1_g[7] | (l1_p[7] & l1_g[5]);
  assign l2_p[4] = l1_p[4];
  assign l2_p[5] = l1_p[5];
  assign l2_p[6] = l1_p[6] & l1_p[5];
  assign l2_p[7] = l1_p[7] & l1_p[5];

  // ---------------- optional S2 register ----------------
  logic             m_valid;
  logic [WIDTH-1:0] m_g, m_h;
  logic [WIDTH-1:4] m_p;
  logic             m_a7, m_b7;
  logic             so_valid;
  logic             so_open;

  assign so_open = ~so_valid | bus.out_ready;

  generate
    if (PIPE_MID != 0) begin : g_mid
      logic             s2_valid;
      logic [WIDTH-1:0] s2_g, s2_h;
      logic [WIDTH-1:4] s2_p;
      logic             s2_a7, s2_b7;
      logic             s2_open;

      assign s2_open = ~s2_valid | so_open;
      assign s1_adv  = s1_valid & s2_open;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_g     <= '0;
          s2_p     <= '0;
          s2_h     <= '0;
          s2_a7    <= 1'b0;
          s2_b7    <= 1'b0;
        end else begin
          s2_valid <= s1_adv | (s2_valid & ~so_open);
          if (s1_adv) begin
            s2_g  <= l2_g;
            s2_p  <= l2_p;
            s2_h  <= s1_h;
            s2_a7 <= s1_a7;
            s2_b7 <= s1_b7;
          end
        end
      end

      assign m_valid = s2_valid;
      assign m_g     = s2_g;
      assign m_p     = s2_p;
      assign m_h     = s2_h;
      assign m_a7    = s2_a7;
      assign m_b7    = s2_b7;
    end else begin : g_nomid
      assign s1_adv  = s1_valid & so_open;
      assign m_valid = s1_valid;
      assign m_g     = l2_g;
      assign m_p     = l2_p;
      assign m_h     = s1_h;
      assign m_a7    = s1_a7;
      assign m_b7    = s1_b7;
    end
  endgenerate

  // ---------------- level 3, sum and flags ----------------
  logic [WIDTH-1:0] l3_g, carry, diff_n;
  logic             borrow_n, zero_n, ovf_n, m_adv;

  assign l3_g[3:0] = m_g[3:0];
  assign l3_g[4]   = m_g[4] | (m_p[4] & m_g[3]);
  assign l3_g[5]   = m_g[5] | (m_p[5] & m_g[3]);
  assign l3_g[6]   = m_g[6] | (m_p[6] & m_g[3]);
  assign l3_g[7]   = m_g[7] | (m_p[7] & m_g[3]);

  // c[i+1] = G[i:0]; c[0] is the forced carry-in.
  assign carry    = {l3_g[6:0], 1'b1};
  assign diff_n   = m_h ^ carry;
  assign borrow_n = ~l3_g[7];
  assign zero_n   = ~|diff_n;
  assign ovf_n    = (m_a7 ^ m_b7) & (diff_n[7] ^ m_a7);
  assign m_adv    = m_valid & so_open;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, zero_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      so_valid <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      so_valid <= m_adv | (so_valid & ~bus.out_ready);
      if (m_adv) begin
        diff_q   <= diff_n;
        borrow_q <= borrow_n;
        zero_q   <= zero_n;
        ovf_q    <= ovf_n;
      end
    end
  end

  assign bus.out_valid = so_valid;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// tb_prefix_subtractor_pipe
//   Directed table of subtraction vectors with hand-computed results, then
//   streaming, backpressure and mid-flight reset sequences checked against
//   an expected-result queue.
module tb_prefix_subtractor_pipe;
  localparam int WIDTH    = 8;
  localparam int PIPE_MID = 1;
  localparam int LAT      = 2 + PIPE_MID;
  localparam int W        = WIDTH + 3;  // {ovf, zero, borrow, diff}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prefix_subtractor_pipe_if #(.WIDTH(WIDTH)) bus ();

  prefix_subtractor_pipe #(
    .WIDTH   (WIDTH),
    .PIPE_MID(PIPE_MID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // ---------------- bookkeeping ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int fire_cnt  = 0;
  int last_fire = -1;
  int gap_err   = 0;
  bit sb_en       = 1'b0;
  bit stream_mode = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       zero;
    logic       ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    logic br, z, o;
    d  = a - b;
    br = (a < b);
    z  = (d == 8'h00);
    o  = (a[7] != b[7]) && (d[7] != a[7]);
    return {o, z, br, d};
  endfunction

  // ---------------- scoreboard (samples on the falling edge) ----------------
  always @(negedge clk) begin
    cyc++;
    if (sb_en) begin
      if (bus.out_valid && bus.out_ready) begin
        fire_cnt++;
        if (stream_mode && last_fire >= 0 && cyc != last_fire + 1) gap_err++;
        last_fire = cyc;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", {21'd0, bus.ovf, bus.zero, bus.borrow, bus.diff}, 32'hFFFF_FFFF);
        end else begin
          sb_exp = exp_q.pop_front();
          check("sb_result", {21'd0, bus.ovf, bus.zero, bus.borrow, bus.diff}, {21'd0, sb_exp});
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b));
    end
  end

  // ---------------- driver tasks (entered at posedge + 1) ----------------
  task automatic drive(input logic [7:0] a, input logic [7:0] b);
    int guard;
    guard      = 0;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("drive_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_vector(input int i);
    int lat;
    @(posedge clk);
    #1;
    bus.a         = vecs[i].a;
    bus.b         = vecs[i].b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);  // accepting edge
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("vec%0d_latency", i), lat, LAT);
    check($sformatf("vec%0d_diff", i), bus.diff, vecs[i].diff);
    check($sformatf("vec%0d_borrow", i), bus.borrow, vecs[i].borrow);
    check($sformatf("vec%0d_zero", i), bus.zero, vecs[i].zero);
    check($sformatf("vec%0d_ovf", i), bus.ovf, vecs[i].ovf);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int k;
    int unstable;
    bit have;
    logic [W-1:0] held;

    //            a      b      diff   brw   zero  ovf
    vecs[0]  = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_diff", bus.diff, 0);
    check("reset_borrow", bus.borrow, 0);
    check("reset_zero", bus.zero, 0);
    check("reset_ovf", bus.ovf, 0);
    check("reset_in_ready", bus.in_ready, 1);

    // directed table
    for (int i = 0; i < 11; i++) run_vector(i);

    // streaming: 256 back-to-back random pairs
    @(posedge clk);
    #1;
    sb_en         = 1'b1;
    stream_mode   = 1'b1;
    fire_cnt      = 0;
    last_fire     = -1;
    gap_err       = 0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 256; n++) drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    bus.in_valid = 1'b0;
    wait_drain();
    check("stream_count", fire_cnt, 256);
    check("stream_gaps", gap_err, 0);
    stream_mode = 1'b0;

    // backpressure: out_ready low for 10 cycles with in_valid held high
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    fire_cnt      = 0;
    acc           = 0;
    k             = 0;
    unstable      = 0;
    have          = 1'b0;
    held          = '0;
    bus.a         = 8'h30;
    bus.b         = 8'h11;
    bus.in_valid  = 1'b1;
    for (int cy = 0; cy < 10; cy++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (!have) begin
          have = 1'b1;
          held = {bus.ovf, bus.zero, bus.borrow, bus.diff};
        end else if ({bus.ovf, bus.zero, bus.borrow, bus.diff} != held) begin
          unstable++;
        end
      end
      if (bus.in_ready) begin
        acc++;
        k++;
        @(posedge clk);
        #1;
        bus.a = 8'h30 + 8'(k * 13);
        bus.b = 8'h11 + 8'(k * 7);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_in_ready_low", bus.in_ready, 0);
    check("bp_accepts", acc, LAT);
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_stable", unstable, 0);
    check("bp_no_output", fire_cnt, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();
    check("bp_delivered", fire_cnt, LAT);

    // reset with three results in flight
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    drive(8'h44, 8'h22);
    drive(8'h99, 8'h10);
    drive(8'h01, 8'h02);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_diff", bus.diff, 0);
    check("midrst_flags", {bus.ovf, bus.zero, bus.borrow}, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    fire_cnt      = 0;
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_stale", fire_cnt, 0);

    // pipeline still works after the reset
    @(posedge clk);
    #1;
    drive(8'h0A, 8'h03);
    bus.in_valid = 1'b0;
    wait_drain();
    check("post_rst_result_count", fire_cnt, 1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/prefix_subtractor_pipe.md
Name: prefix_subtractor_pipe

Overview:
- Pipelined 8-bit unsigned/two's-complement subtractor, the inverse-direction companion to the team's combinational 8-bit parallel-prefix adder.
- Computes diff = a - b as a + ~b + 1 on the same Ladner-Fischer-style prefix carry network, with a forced carry-in of 1.
- Adds registered pipeline stages, a valid/ready handshake on both sides, and borrow, zero and signed-overflow flags.
- Sits between an operand-producing stage and any consumer that can apply backpressure.

Parameters:
- WIDTH, 8: operand width. Only 8 is supported; the prefix network is fixed at 3 levels.
- PIPE_MID, 1: 1 inserts a register after prefix level 2 (latency 3); 0 omits it (latency 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair a/b is valid
- in_ready  output  1  block can accept operands this cycle
- a  input  8  minuend
- b  input  8  subtrahend
- out_valid  output  1  diff and flags are valid
- out_ready  input  1  consumer accepts the result this cycle
- diff  output  8  (a - b) mod 256
- borrow  output  1  1 when a < b, unsigned
- zero  output  1  1 when diff == 0
- ovf  output  1  signed overflow: a[7] != b[7] and diff[7] != a[7]

Behaviour:
- Reset: on a clk edge with rst=1, all stage valid bits clear and all data registers go to 0.
  - Outputs: out_valid=0, diff=0x00, borrow=0, zero=0, ovf=0.
  - in_ready=1 from the first cycle after reset. rst overrides any simultaneous handshake.
  - Reset mid-operation discards all in-flight results; none is ever presented.
- Stage S1, captured on accept:
  - bb = ~b.
  - p[i] = a[i] | bb[i], g[i] = a[i] & bb[i], h[i] = a[i] ^ bb[i].
  - Register p, g, h and a[7], b[7].
- Carry-in: cin = 1. It is folded into bit 0 as G0 = g[0] | p[0].
- Prefix network, 3 levels:
  - Group (P,G) combine: G = Ghi | (Phi & Glo), P = Phi & Plo.
  - Produces carries c[i+1] = G[i:0] for i = 0..6; c[0] = cin.
- Stage S2 (present only when PIPE_MID=1): registers the level-2 group P/G, plus h and the sign bits.
- Output stage SO:
  - diff[i] = h[i] ^ c[i].
  - carry_out = G[7:0].
  - borrow = ~carry_out.
  - zero = (diff == 0).
  - ovf computed as defined under Ports.
- Latency: with no stall, out_valid rises exactly 2+PIPE_MID clk edges after the accepting edge.
- Throughput: one result per cycle when out_ready is held at 1.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - A stage advances when its successor is empty or its successor advances in the same cycle.
  - in_ready = ~S1.valid | S1.advance. This is combinational from out_ready through the stage chain; there is no skid buffer.
  - When out_valid=1 and out_ready=0: diff and flags hold stable, and no stage overwrites a full successor.
  - After upstream stages fill, in_ready drops.
  - Inputs are ignored while in_valid=0 or in_ready=0.
- Simultaneous events: an output transfer and a new input accept in the same cycle are both honoured with no bubble.
- Ordering: results emerge strictly in acceptance order; none is dropped or duplicated.
- Gate-level: prefix and sum logic is built from the shared 2-input and/xor/or cells. Registers are behavioural.

Test Plan:
- Basic subtraction: reset, then a=0x05, b=0x03, out_ready=1.
  - diff=0x02, borrow=0, zero=0, ovf=0.
  - out_valid rises 3 edges after accept (PIPE_MID=1), or 2 edges (PIPE_MID=0).
- Borrow and zero cases:
  - a=0x03, b=0x05 -> diff=0xFE, borrow=1.
  - a=0x5A, b=0x5A -> diff=0x00, zero=1, borrow=0.
  - a=0x00, b=0xFF -> diff=0x01, borrow=1.
- Signed overflow:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow=0.
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1, borrow=1.
- Streaming: 256 back-to-back random pairs with out_ready=1.
  - One result per cycle after fill, in order.
  - Every result matches a reference model of a-b plus flags.
- Backpressure: hold out_ready=0 for 10 cycles while in_valid=1.
  - in_ready falls after 2+PIPE_MID accepts; diff is stable while stalled.
  - Release gives in-order delivery with no loss or duplication.
- Reset mid-operation: assert rst for 1 cycle with 3 results in flight.
  - Next cycle: out_valid=0, outputs 0, in_ready=1.
  - No stale result appears afterwards.
